// File: rtl/vga_frame_commit_ctrl.sv
// Double-buffered scene registers for the VGA sprite/background datapath: software edits shadow
// copies, and a commit request moves them to the active set at the next vblank start. Build with FRAME_IRQ_EN for the frame interrupt.
module vga_frame_commit_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  boundary_1,
  output logic [9:0]  boundary_2,
  output logic [9:0]  boundary_3,
  output logic [9:0]  boundary_4,
  output logic [9:0]  sprite1_x,
  output logic [9:0]  sprite1_y,
  output logic [4:0]  sprite1_img,
  output logic [9:0]  sprite2_x,
  output logic [9:0]  sprite2_y,
  output logic [4:0]  sprite2_img,
  output logic        irq
);

  localparam int          NUM_SCENE  = 10;
  localparam logic [5:0]  ADDR_CTRL  = 6'hA;
  localparam logic [5:0]  ADDR_STAT  = 6'hB;
  localparam logic [5:0]  ADDR_FRAME = 6'hC;
  localparam logic [9:0]  VBLANK_LINE = 10'd480;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  shadow_q [NUM_SCENE];
  logic [9:0]  shadow_d [NUM_SCENE];
  logic [9:0]  active_q [NUM_SCENE];
  logic [9:0]  active_d [NUM_SCENE];
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] readdata_q, readdata_d;
  logic        irq_flag;

  logic vblank_start;
  logic wr_en;
  logic rd_en;
  logic commit_req;
  logic irq_ack;
  logic commit;

  // Image-select slots (words 6 and 9) only hold 5 bits; everything else holds 10.
  function automatic logic [9:0] shadow_wdata(input int idx, input logic [15:0] wd);
    if (idx == 6 || idx == 9) begin
      return {5'd0, wd[4:0]};
    end
    return wd[9:0];
  endfunction

  function automatic logic [15:0] reg_read(input logic [5:0] addr);
    logic [15:0] val;
    val = 16'd0;
    for (int i = 0; i < NUM_SCENE; i++) begin
      if (addr == 6'(i)) begin
        val = {6'd0, shadow_q[i]};
      end
    end
    if (addr == ADDR_STAT) begin
      val = {frame_count_q[7:0], 6'd0, irq_flag, (state_q == ST_PENDING)};
    end else if (addr == ADDR_FRAME) begin
      val = frame_count_q;
    end
    return val;
  endfunction

  always_comb begin
    vblank_start = (vcount == VBLANK_LINE) && (hcount == 11'd0);
    wr_en        = chipselect && write;
    rd_en        = chipselect && read;
    commit_req   = wr_en && (address == ADDR_CTRL) && writedata[0];
    irq_ack      = wr_en && (address == ADDR_CTRL) && writedata[1];
  end

  // A request arriving on the vblank_start cycle itself lands in PENDING and waits a full frame.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (vblank_start) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit copies the registered shadow, so a same-cycle shadow write waits for the next commit.
  always_comb begin
    for (int i = 0; i < NUM_SCENE; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_en && (address == 6'(i))) begin
        shadow_d[i] = shadow_wdata(i, writedata);
      end
      if (commit) begin
        active_d[i] = shadow_q[i];
      end
    end
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (vblank_start) begin
      frame_count_d = frame_count_q + 16'd1;
    end
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = reg_read(address);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_count_q <= 16'd0;
      readdata_q    <= 16'd0;
      for (int i = 0; i < NUM_SCENE; i++) begin
        shadow_q[i] <= 10'd0;
        active_q[i] <= 10'd0;
      end
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
      for (int i = 0; i < NUM_SCENE; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

`ifdef FRAME_IRQ_EN
  logic irq_q, irq_d;

  // Setting wins over a coincident acknowledge so no frame edge is lost.
  always_comb begin
    irq_d = irq_q;
    if (vblank_start) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_flag = irq_q;
`else
  logic unused_ack;
  assign unused_ack = irq_ack;
  assign irq_flag   = 1'b0;
`endif

  assign irq         = irq_flag;
  assign readdata    = readdata_q;
  assign boundary_1  = active_q[0];
  assign boundary_2  = active_q[1];
  assign boundary_3  = active_q[2];
  assign boundary_4  = active_q[3];
  assign sprite1_x   = active_q[4];
  assign sprite1_y   = active_q[5];
  assign sprite1_img = active_q[6][4:0];
  assign sprite2_x   = active_q[7];
  assign sprite2_y   = active_q[8];
  assign sprite2_img = active_q[9][4:0];

  logic unused_bits;
  assign unused_bits = ^{writedata[15:10], active_q[6][9:5], active_q[9][9:5]};

endmodule
